// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC step, default reset/exception vectors,
// and the next-PC source select encoding.
package cpu_pkg;

  localparam int          PC_STEP            = 4;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_EXC = 3'd4
  } pc_src_e;

endpackage : cpu_pkg

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count; a full push overwrites
// the oldest entry, and push+pop in one cycle replaces the top in place.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign top    = mem[ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      ptr   <= ptr + PW'(1);
      count <= full ? count : count + CW'(1);
    end else if (do_pop && !push) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // NOTE: entries are never read while count says empty, so the storage array
  // carries no reset and maps onto plain flops/LUT-RAM without a clear path.
  always_ff @(posedge clk) begin
    if (push && do_pop)
      mem[ptr] <= push_data;
    else if (push)
      mem[ptr + PW'(1)] <= push_data;
  end

endmodule : ras_stack

// File: rtl/next_pc_unit.sv
// Program counter register and next-PC selection: sequential, branch, jump,
// register jump with RAS return prediction, and misaligned-target trap.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter int          AW         = 32,
  parameter logic [AW-1:0] RESET_PC   = AW'(RESET_PC_DEFAULT),
  parameter int          RAS_DEPTH  = 4,
  parameter logic [AW-1:0] EXC_VECTOR = AW'(EXC_VECTOR_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_valid,
  input  logic          br_taken,
  input  logic [15:0]   br_offset,
  input  logic          j_valid,
  input  logic [25:0]   j_target,
  input  logic          jr_valid,
  input  logic [AW-1:0] jr_addr,
  input  logic          jr_use_ras,
  input  logic          link,
  output logic [AW-1:0] pc_out,
  output logic          redirect,
  output logic          exc_misalign,
  output logic          ras_empty,
  output logic          ras_full
);

  logic [AW-1:0] pc4;
  logic [AW-1:0] br_addr;
  logic [AW-1:0] j_addr;
  logic [AW-1:0] jr_sel;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] next_pc;
  logic          misalign;
  logic          ras_push;
  logic          ras_pop;
  pc_src_e       src;

  assign pc4     = pc_out + AW'(PC_STEP);
  assign br_addr = pc4 + {{(AW-18){br_offset[15]}}, br_offset, 2'b00};

  // Pseudo-direct jumps keep the region bits above the 28-bit jump span.
  if (AW > 28) begin : g_j_region
    assign j_addr = {pc4[AW-1:28], j_target, 2'b00};
  end else begin : g_j_flat
    assign j_addr = {j_target, 2'b00};
  end

  assign jr_sel   = (jr_use_ras && !ras_empty) ? ras_top : jr_addr;
  assign misalign = jr_valid && (jr_sel[1:0] != 2'b00);

  // NOTE: every variable gets a default before the priority chain so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    src     = SRC_SEQ;
    next_pc = pc4;
    if (jr_valid)                 src = misalign ? SRC_EXC : SRC_JR;
    else if (j_valid)             src = SRC_J;
    else if (br_valid && br_taken) src = SRC_BR;

    unique case (src)
      SRC_BR:  next_pc = br_addr;
      SRC_J:   next_pc = j_addr;
      SRC_JR:  next_pc = jr_sel;
      SRC_EXC: next_pc = EXC_VECTOR;
      default: next_pc = pc4;
    endcase
  end

  // A trapped register jump must not leave a stale return address behind.
  assign ras_push = link && !stall && (src != SRC_EXC);
  assign ras_pop  = jr_valid && jr_use_ras && !stall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out       <= RESET_PC;
      redirect     <= 1'b0;
      exc_misalign <= 1'b0;
    end else if (stall) begin
      redirect     <= 1'b0;
      exc_misalign <= 1'b0;
    end else begin
      pc_out       <= next_pc;
      redirect     <= (src != SRC_SEQ);
      exc_misalign <= (src == SRC_EXC);
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule : next_pc_unit

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: sequencing, branch/jump priority, RAS
// push/pop/overflow, misalign trap, stall hold and asynchronous reset.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        j_valid;
  logic [25:0] j_target;
  logic        jr_valid;
  logic [31:0] jr_addr;
  logic        jr_use_ras;
  logic        link;
  logic [31:0] pc_out;
  logic        redirect;
  logic        exc_misalign;
  logic        ras_empty;
  logic        ras_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .j_valid      (j_valid),
    .j_target     (j_target),
    .jr_valid     (jr_valid),
    .jr_addr      (jr_addr),
    .jr_use_ras   (jr_use_ras),
    .link         (link),
    .pc_out       (pc_out),
    .redirect     (redirect),
    .exc_misalign (exc_misalign),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; br_valid = 0; br_taken = 0; br_offset = '0;
    j_valid = 0; j_target = '0; jr_valid = 0; jr_addr = '0;
    jr_use_ras = 0; link = 0;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jr(input logic [31:0] addr);
    idle(); jr_valid = 1; jr_addr = addr;
    step();
    idle();
  endtask

  task automatic do_jal(input logic [25:0] tgt);
    idle(); j_valid = 1; j_target = tgt; link = 1;
    step();
    idle();
  endtask

  task automatic do_ret(input logic [31:0] fallback);
    idle(); jr_valid = 1; jr_use_ras = 1; jr_addr = fallback;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("rst_pc", pc_out, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_exc", {31'b0, exc_misalign}, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_full", {31'b0, ras_full}, 32'h0);
    @(negedge clk);
    rst = 0;

    // Sequential increment
    step(); check("seq_pc4", pc_out, 32'h4);
    step(); check("seq_pc8", pc_out, 32'h8);
    step(); check("seq_pcC", pc_out, 32'hC);
    check("seq_redirect", {31'b0, redirect}, 32'h0);
    check("seq_empty", {31'b0, ras_empty}, 32'h1);

    // Backward branch taken: 0x104 + (-4 << 2) = 0xF4
    do_jr(32'h100);
    check("jr_pc", pc_out, 32'h100);
    check("jr_redirect", {31'b0, redirect}, 32'h1);
    br_valid = 1; br_taken = 1; br_offset = 16'hFFFC;
    step(); idle();
    check("br_taken_pc", pc_out, 32'hF4);
    check("br_taken_redirect", {31'b0, redirect}, 32'h1);
    do_jr(32'h100);
    br_valid = 1; br_taken = 0; br_offset = 16'hFFFC;
    step(); idle();
    check("br_not_taken_pc", pc_out, 32'h104);
    check("br_not_taken_redirect", {31'b0, redirect}, 32'h0);

    // Pseudo-direct jump keeps region bits; jr beats j
    do_jr(32'h3000_0010);
    j_valid = 1; j_target = 26'h40;
    step(); idle();
    check("j_pc", pc_out, 32'h3000_0100);
    j_valid = 1; j_target = 26'h40; jr_valid = 1; jr_addr = 32'h200;
    br_valid = 1; br_taken = 1; br_offset = 16'h0010;
    step(); idle();
    check("prio_jr_pc", pc_out, 32'h200);

    // Five JAL pushes into a 4-deep RAS
    do_jr(32'h10);
    do_jal(26'h8);
    check("jal1_pc", pc_out, 32'h20);
    check("jal1_empty", {31'b0, ras_empty}, 32'h0);
    do_jal(26'hC);
    do_jal(26'h10);
    check("jal3_full", {31'b0, ras_full}, 32'h0);
    do_jal(26'h14);
    check("jal4_full", {31'b0, ras_full}, 32'h1);
    do_jal(26'h18);
    check("jal5_pc", pc_out, 32'h60);
    check("jal5_full", {31'b0, ras_full}, 32'h1);

    do_ret(32'h700); check("ret1_pc", pc_out, 32'h54);
    check("ret1_full", {31'b0, ras_full}, 32'h0);
    do_ret(32'h700); check("ret2_pc", pc_out, 32'h44);
    do_ret(32'h700); check("ret3_pc", pc_out, 32'h34);
    do_ret(32'h700); check("ret4_pc", pc_out, 32'h24);
    check("ret4_empty", {31'b0, ras_empty}, 32'h1);
    do_ret(32'h700); check("ret5_fallback_pc", pc_out, 32'h700);
    check("ret5_redirect", {31'b0, redirect}, 32'h1);

    // JALR through RAS: read old top, write pc4 into the same slot
    do_jal(26'h200);
    check("push_pc", pc_out, 32'h800);
    idle(); jr_valid = 1; jr_use_ras = 1; link = 1; jr_addr = 32'h900;
    step(); idle();
    check("jalr_ras_pc", pc_out, 32'h704);
    check("jalr_ras_empty", {31'b0, ras_empty}, 32'h0);
    do_ret(32'h900);
    check("jalr_ras_ret_pc", pc_out, 32'h804);
    check("jalr_ras_ret_empty", {31'b0, ras_empty}, 32'h1);

    // Misaligned register target traps and suppresses the link push
    idle(); jr_valid = 1; jr_addr = 32'h102; link = 1;
    step(); idle();
    check("mis_pc", pc_out, 32'h8000_0180);
    check("mis_exc", {31'b0, exc_misalign}, 32'h1);
    check("mis_redirect", {31'b0, redirect}, 32'h1);
    check("mis_no_push", {31'b0, ras_empty}, 32'h1);
    step();
    check("mis_exc_pulse", {31'b0, exc_misalign}, 32'h0);
    check("mis_next_pc", pc_out, 32'h8000_0184);

    // Stall holds PC and RAS; requests are dropped
    do_jr(32'h8000_0180);
    do_jal(26'h100);
    check("pre_stall_pc", pc_out, 32'h8000_0400);
    stall = 1; br_valid = 1; br_taken = 1; br_offset = 16'h0010; link = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_out, 32'h8000_0400);
      check("stall_redirect", {31'b0, redirect}, 32'h0);
    end
    idle();
    do_ret(32'h500);
    check("post_stall_ret_pc", pc_out, 32'h8000_0184);
    check("post_stall_empty", {31'b0, ras_empty}, 32'h1);

    // Asynchronous reset in the middle of a stall
    do_jal(26'h40);
    check("pre_rst_empty", {31'b0, ras_empty}, 32'h0);
    stall = 1; br_valid = 1; br_taken = 1; br_offset = 16'h0010;
    step();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_empty", {31'b0, ras_empty}, 32'h1);
    check("midrst_redirect", {31'b0, redirect}, 32'h0);
    idle();
    @(negedge clk);
    rst = 0;
    step();
    check("after_rst_pc", pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_next_pc_unit

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Parametrised successor to the current branch adder: owns the program counter register and computes the next PC every cycle.
- Next-PC sources: sequential increment, PC-relative branch, pseudo-direct jump, register jump, and return prediction from a small return-address stack (RAS).
- Adds stall hold, misaligned-target trap and a registered redirect flag; sits between decode/branch-compare logic and instruction fetch.

Parameters:
- AW, 32, PC/address width (>= 28)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)
- EXC_VECTOR, 32'h8000_0180, PC loaded on misaligned register-jump target

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and all internal state this cycle
- br_valid  in  1  current instruction is a conditional branch
- br_taken  in  1  branch condition true (qualified by br_valid)
- br_offset  in  16  signed word offset of branch
- j_valid  in  1  pseudo-direct jump (J/JAL)
- j_target  in  26  jump index field
- jr_valid  in  1  register jump (JR/JALR)
- jr_addr  in  AW  register jump target
- jr_use_ras  in  1  with jr_valid: use RAS top instead of jr_addr if RAS non-empty; pops RAS
- link  in  1  instruction links (JAL/JALR): push pc_out+4 onto RAS
- pc_out  out  AW  current PC
- redirect  out  1  last PC update was non-sequential
- exc_misalign  out  1  one-cycle pulse: jr target low bits nonzero
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, while rst=1): pc_out=RESET_PC, redirect=0, exc_misalign=0, RAS count=0, pointer=0, ras_empty=1, ras_full=0.
- All inputs refer to the instruction at pc_out; result visible on pc_out one cycle later (latency 1).
- pc4 = pc_out + 4, modulo 2^AW (wraps silently).
- Branch target = pc4 + (sign_extend(br_offset) << 2), AW-bit modulo arithmetic.
- Jump target = {pc4[AW-1:28], j_target, 2'b00}.
- Register target = RAS top if jr_use_ras and !ras_empty, else jr_addr.
- Priority when several valid: jr_valid > j_valid > (br_valid & br_taken) > sequential. Lower-priority requests are ignored.
- Misalign: selected register target [1:0] != 0 -> next PC = EXC_VECTOR, exc_misalign=1 next cycle, link push suppressed. Only register targets are checked.
- redirect registered: 1 next cycle iff a non-sequential source (incl. EXC_VECTOR) was selected and stall=0; otherwise 0.
- stall=1: pc_out, RAS and pointer unchanged; redirect and exc_misalign driven 0 next cycle; all requests dropped (upstream re-presents them).
- RAS is a circular buffer with top pointer and saturating count.
  - Push: write pc4 at top+1, advance pointer; count = min(count+1, RAS_DEPTH); full push overwrites oldest.
  - Pop (jr_valid & jr_use_ras & !empty): retreat pointer, count-1.
  - Pop on empty: no change; jr_addr used.
  - Push and pop in the same cycle (JALR via RAS): target read from old top, then pc4 written into that same slot; pointer and count unchanged.
  - link with non-winning source still pushes (decode guarantees consistency).
- Reset asserted mid-operation: immediate return to reset values; the pending update is lost.

Decomposition:
- Shared package cpu_pkg: PC_STEP=4, RESET_PC and EXC_VECTOR defaults, next-PC source select encoding (SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_EXC).
- Sub-module ras_stack (parameter DEPTH, AW): push/pop/top/empty/full with the same-cycle rules above. Top-level holds PC register, target arithmetic and priority mux.

Test Plan:
- Reset, 3 idle cycles -> pc_out 0,4,8,C; redirect=0; ras_empty=1.
- pc_out=0x100, br_valid=1, br_taken=1, br_offset=16'hFFFC -> pc_out=0xF4, redirect=1; br_taken=0 gives 0x104, redirect=0.
- pc_out=0x3000_0010, j_valid=1, j_target=26'h40 -> pc_out=0x3000_0100. Same cycle with jr_valid=1, jr_addr=0x200 -> pc_out=0x200 (priority).
- 5 JAL pushes at pc 0x10,0x20,0x30,0x40,0x50 (DEPTH=4) -> ras_full=1. 4 RAS pops return 0x54,0x44,0x34,0x24; 5th pop uses jr_addr.
- jr_valid=1, jr_addr=0x102 -> pc_out=EXC_VECTOR, exc_misalign pulse 1 cycle, no RAS push even with link=1.
- stall=1 for 3 cycles with br request -> pc_out, RAS unchanged. rst mid-stall -> pc_out=RESET_PC immediately, RAS empty.
